// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port, variable-latency memory between
//   the instruction-fetch port and the data-memory port, one transaction in flight.
// Latency: best case 3 cycles from request seen in IDLE to the valid pulse
//   (IDLE -> ISSUE -> WAIT -> RESP). Throughput: at most one transaction per 4 cycles.
// Backpressure: requesters hold req until their valid pulse; the block stalls in
//   ISSUE until mem_gnt and in WAIT until mem_rvalid. Data wins over fetch except
//   when MAX_DM_STREAK consecutive data grants were made against a pending fetch.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_if_*/o_if_*           fetch request (req/addr/kill) and response (rdata/valid)
//   i_dm_*/o_dm_*           data request (req/we/addr/wdata/be) and response (rdata/valid)
//   o_mem_*/i_mem_*         memory request with latched attributes; gnt/rvalid/rdata back
//   o_stall_if, o_stall_dm  per-stage stall requests to the hazard unit
//   o_protocol_err          sticky flag: mem_rvalid seen outside WAIT
module unified_mem_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int CNT_W         = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_kill,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_be,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_valid,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall_if,
  output logic        o_stall_dm,
  output logic        o_protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} own_t;

  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(MAX_DM_STREAK);

  state_t            r_state;
  state_t            w_state_nxt;
  own_t              r_own;
  logic [CNT_W-1:0]  r_streak;
  logic              r_killed;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_dm_rdata;
  logic              r_if_valid;
  logic              r_dm_valid;
  logic              r_protocol_err;

  logic              w_if_elig;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic              w_resp;

  // A fetch being flushed this cycle must not win arbitration.
  assign w_if_elig = i_if_req & ~i_if_kill;
  assign w_resp    = (r_state == S_WAIT) & i_mem_rvalid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_dm  = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dm_req && w_if_elig) begin
          // Streak is the count before this grant, so grant MAX_DM_STREAK+1 goes to fetch.
          if (r_streak == L_MAX) w_grant_if = 1'b1;
          else                   w_grant_dm = 1'b1;
        end else if (i_dm_req) begin
          w_grant_dm = 1'b1;
        end else if (w_if_elig) begin
          w_grant_if = 1'b1;
        end
        if (w_grant_dm || w_grant_if) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: if (i_mem_gnt)    w_state_nxt = S_WAIT;
      S_WAIT:  if (i_mem_rvalid) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_own          <= OWN_FETCH;
      r_streak       <= '0;
      r_killed       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_if_rdata     <= '0;
      r_dm_rdata     <= '0;
      r_if_valid     <= 1'b0;
      r_dm_valid     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      // Request attributes are captured once at grant and held through ISSUE.
      if (w_grant_dm) begin
        r_own       <= OWN_DATA;
        r_mem_we    <= i_dm_we;
        r_mem_addr  <= i_dm_addr;
        r_mem_wdata <= i_dm_wdata;
        r_mem_be    <= i_dm_be;
      end else if (w_grant_if) begin
        r_own       <= OWN_FETCH;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= i_if_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= 4'hF;
      end

      if (!i_if_req || w_grant_if)
        r_streak <= '0;
      else if (w_grant_dm && (r_streak != L_MAX))
        r_streak <= r_streak + 1'b1;

      // The memory side has no cancel, so a killed fetch runs to completion
      // and only its response is suppressed.
      if (r_state == S_RESP)
        r_killed <= 1'b0;
      else if (((r_state == S_ISSUE) || (r_state == S_WAIT)) && (r_own == OWN_FETCH) && i_if_kill)
        r_killed <= 1'b1;

      // Valids are registered on the WAIT->RESP edge so they pulse exactly during RESP.
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      if (w_resp) begin
        if (r_own == OWN_DATA) begin
          r_dm_rdata <= i_mem_rdata;
          r_dm_valid <= 1'b1;
        end else if (!r_killed && !i_if_kill) begin
          r_if_rdata <= i_mem_rdata;
          r_if_valid <= 1'b1;
        end
      end

      if (i_mem_rvalid && (r_state != S_WAIT))
        r_protocol_err <= 1'b1;
    end
  end

  assign o_mem_req      = (r_state == S_ISSUE);
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_be       = r_mem_be;
  assign o_if_rdata     = r_if_rdata;
  assign o_if_valid     = r_if_valid;
  assign o_dm_rdata     = r_dm_rdata;
  assign o_dm_valid     = r_dm_valid;
  assign o_protocol_err = r_protocol_err;
  assign o_stall_if     = i_if_req & ~r_if_valid & ~i_if_kill;
  assign o_stall_dm     = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed stimulus for unified_mem_arbiter with a
//   scoreboard queue of expected responses, a monitor that checks every valid
//   pulse, and a small memory model with programmable grant/response delays.
module tb_unified_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_kill;
  logic [31:0] if_addr, if_rdata;
  logic        if_valid;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_dm, protocol_err;

  int n_chk;
  int n_fail;
  int gnt_dly;
  int rv_dly;
  bit force_rv;

  typedef struct {
    logic        is_fetch;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  unified_mem_arbiter #(.MAX_DM_STREAK(4), .CNT_W(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_rdata(if_rdata), .o_if_valid(if_valid),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
    .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
    .o_dm_rdata(dm_rdata), .o_dm_valid(dm_valid),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_stall_if(stall_if), .o_stall_dm(stall_dm), .o_protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_fetch, input logic chk_data, input logic [31:0] data);
    exp_t e;
    e.is_fetch = is_fetch;
    e.chk_data = chk_data;
    e.data     = data;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the requester's valid pulse, then drop its request during RESP.
  task automatic wait_valid(input bit fetch, input int budget);
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      seen = fetch ? if_valid : dm_valid;
    end
    chk1(fetch ? "if_valid_wait" : "dm_valid_wait", seen, 1'b1);
    if (fetch) if_req = 1'b0;
    else       dm_req = 1'b0;
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h40:  return 32'h13;
      default: return ~a;
    endcase
  endfunction

  // Memory model: gnt after gnt_dly unanswered ISSUE cycles, rvalid rv_dly cycles after gnt.
  initial begin : mem_model
    int          m_phase;
    int          m_cnt;
    logic [31:0] m_addr;
    m_phase = 0; m_cnt = 0; m_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        m_phase = 0;
        m_cnt   = 0;
      end else begin
        if (force_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'h5555AAAA;
        end
        if (m_phase == 2) begin
          if (m_cnt == rv_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(m_addr);
            m_phase    = 0;
            m_cnt      = 0;
          end else begin
            m_cnt++;
          end
        end else if (mem_req) begin
          if (m_cnt == gnt_dly) begin
            mem_gnt = 1'b1;
            m_addr  = mem_addr;
            m_phase = 2;
            m_cnt   = 1;
          end else begin
            m_cnt++;
          end
        end else begin
          m_cnt = 0;
        end
      end
    end
  end

  // Monitor: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && (if_valid || dm_valid)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: actual if_valid=%b dm_valid=%b required no pulse at %0t",
                 if_valid, dm_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        chk1("resp_owner_is_fetch", if_valid, mon_e.is_fetch);
        chk1("resp_single_valid", if_valid & dm_valid, 1'b0);
        if (mon_e.chk_data)
          chk32("resp_data", if_valid ? if_rdata : dm_rdata, mon_e.data);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1);
  end

  initial begin : main
    int k;
    int cnt;
    n_chk = 0; n_fail = 0;
    gnt_dly = 0; rv_dly = 1; force_rv = 1'b0;
    rst_n = 1'b0;
    if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_dm_valid", dm_valid, 1'b0);
    chk1("rst_protocol_err", protocol_err, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_dm_rdata", dm_rdata, 32'h0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_be", {28'h0, mem_be}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single load with best-case latency
    @(posedge clk); #1;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    dm_we = 1'b0; dm_addr = 32'h100; dm_req = 1'b1;
    @(negedge clk);
    chk1("ld_c0_stall_dm", stall_dm, 1'b1);
    chk1("ld_c0_mem_req", mem_req, 1'b0);
    @(negedge clk);
    chk1("ld_c1_mem_req", mem_req, 1'b1);
    chk32("ld_c1_mem_addr", mem_addr, 32'h100);
    chk1("ld_c1_mem_we", mem_we, 1'b0);
    chk1("ld_c1_stall_dm", stall_dm, 1'b1);
    @(negedge clk);
    chk1("ld_c2_mem_req", mem_req, 1'b0);
    chk1("ld_c2_stall_dm", stall_dm, 1'b1);
    @(negedge clk);
    chk1("ld_c3_dm_valid", dm_valid, 1'b1);
    chk1("ld_c3_stall_dm", stall_dm, 1'b0);
    dm_req = 1'b0;

    // Store with grant delayed 5 cycles: request attributes must hold
    @(posedge clk); #1;
    gnt_dly = 5;
    push_exp(1'b0, 1'b0, 32'h0);
    dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h180; dm_wdata = 32'hCAFE1234; dm_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("st_mem_req", mem_req, 1'b1);
      chk1("st_mem_we", mem_we, 1'b1);
      chk32("st_mem_be", {28'h0, mem_be}, 32'h3);
      chk32("st_mem_addr", mem_addr, 32'h180);
      chk32("st_mem_wdata", mem_wdata, 32'hCAFE1234);
    end
    wait_valid(1'b0, 40);
    dm_we = 1'b0;
    gnt_dly = 0;

    // Both requesters held: D,D,D,D,F repeating
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push_exp(1'b1, 1'b1, 32'hFFFFFDFF);
      else              push_exp(1'b0, 1'b1, 32'hFFFFFCFF);
    end
    if_addr = 32'h200; dm_addr = 32'h300; if_req = 1'b1; dm_req = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 10 && k < 400) begin
      @(negedge clk);
      k++;
      if (if_valid || dm_valid) cnt++;
    end
    chk32("arb_resp_count", 32'(cnt), 32'd10);
    if_req = 1'b0; dm_req = 1'b0;

    // Fetch killed while in WAIT: response discarded
    @(posedge clk); #1;
    rv_dly = 3; if_addr = 32'h40; if_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_gnt && k < 20);
    chk1("kill_gnt_seen", mem_gnt, 1'b1);
    @(posedge clk); #1;
    if_kill = 1'b1;
    @(negedge clk);
    chk1("kill_stall_if", stall_if, 1'b0);
    @(posedge clk); #1;
    if_kill = 1'b0; if_req = 1'b0;
    repeat (8) @(negedge clk);
    chk32("kill_if_rdata_kept", if_rdata, 32'hFFFFFDFF);
    chk1("kill_mem_req_idle", mem_req, 1'b0);
    rv_dly = 1;
    // The next fetch must proceed normally
    @(posedge clk); #1;
    push_exp(1'b1, 1'b1, 32'hFFFFFDFF);
    if_addr = 32'h200; if_req = 1'b1;
    wait_valid(1'b1, 20);

    // Stray rvalid in IDLE: sticky protocol error
    @(posedge clk); #1;
    chk1("perr_before", protocol_err, 1'b0);
    force_rv = 1'b1;
    @(posedge clk); #1;
    force_rv = 1'b0;
    chk1("perr_set", protocol_err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk1("perr_sticky", protocol_err, 1'b1);

    // Reset asserted while in WAIT
    rv_dly = 6; dm_addr = 32'h500; dm_we = 1'b0; dm_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_gnt && k < 20);
    chk1("mr_gnt_seen", mem_gnt, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk1("mr_mem_req", mem_req, 1'b0);
    chk1("mr_dm_valid", dm_valid, 1'b0);
    chk1("mr_if_valid", if_valid, 1'b0);
    chk1("mr_protocol_err", protocol_err, 1'b0);
    chk32("mr_dm_rdata", dm_rdata, 32'h0);
    chk32("mr_if_rdata", if_rdata, 32'h0);
    chk32("mr_mem_addr", mem_addr, 32'h0);
    chk32("mr_mem_wdata", mem_wdata, 32'h0);
    chk32("mr_mem_be", {28'h0, mem_be}, 32'h0);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_dly = 1;
    @(posedge clk); #1;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    dm_addr = 32'h100; dm_req = 1'b1;
    wait_valid(1'b0, 20);
    @(posedge clk); #1;
    chk1("mr_perr_after", protocol_err, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk32("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
